jtag_scan_ctrl: RTL and testbench
=================================

# jtag_scan_ctrl

- Master-side JTAG scan sequencer.
- Accepts scan commands on a valid/ready port and walks the target TAP through the IEEE 1149.1 state graph by driving `tms`/`tdi`.
- Shifts up to 32 bits into IR or DR LSB-first, captures `tdo`, and returns the captured word on a valid/ready response port.
- Sits between the test-host command logic and the `jtag_if` master modport.

## Interface

Clocking: one clock; reset is synchronous and active-high.

Parameters:
- `MAX_LEN`, 32: maximum scan length in bits.
- `LEN_W`, $clog2(MAX_LEN+1): width of the length field.

Ports:
- `tck` in 1: clock; all state changes on posedge.
- `trst` in 1: synchronous active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted on a cycle where valid and ready are both high.
- `cmd_op` in 2: operation. 0 = TAP_RESET, 1 = SCAN_IR, 2 = SCAN_DR, 3 = IDLE_CYC.
- `cmd_len` in LEN_W: meaning depends on op.
  - SCAN_IR / SCAN_DR: bit count.
  - IDLE_CYC: cycle count.
- `cmd_data` in MAX_LEN: data to shift, bit 0 first.
- `rsp_valid` out 1: captured data available (scan ops only).
- `rsp_ready` in 1: response consumed.
- `rsp_data` out MAX_LEN: captured `tdo` bits, bit 0 = first captured.
- `tms` out 1: to `jtag_if.tms`; registered.
- `tdi` out 1: to `jtag_if.tdi`; registered.
- `tdo` in 1: from `jtag_if.tdo`.
- `tap_state` out 4: mirror of the target TAP state, IEEE encoding.

## Operation

TAP mirror:
- On every posedge: `tap_state <= next(tap_state, tms)`, using the `tms` value currently driven.
- `tms`/`tdi` are updated on the same edge and take effect at the next edge.

Reset (`trst`=1):
- Outputs: `tap_state`=TLR, `tms`=1, `tdi`=0, `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0.
- Any command in flight is discarded.
- After release: drive `tms`=0 for one edge (TLR→RTI). `cmd_ready` rises once `tap_state`=RTI.

Controller FSM states: WALK_RTI, READY, NAV, SHIFT, EXIT, RUNIDLE, TLR_SEQ, RESP.
- READY: `cmd_ready`=1 only here, with `tap_state`=RTI, `tms`=0, and no response pending.
- NAV: tms sequence RTI→Shift.
  - DR: 1,0,0.
  - IR: 1,1,0,0.
- SHIFT: N edges in Shift-xR.
  - `tdi` = `cmd_data[i]` on the edge shifting bit i.
  - `tms`=0 for bits 0..N-2, `tms`=1 on bit N-1 (enters Exit1).
  - `tdo` is sampled on each of these N edges into `rsp_data[i]`.
- EXIT: `tms` 1 then 0 (Exit1→Update→RTI). `rsp_valid` rises on the edge entering RTI.
- RESP: hold `rsp_data`/`rsp_valid` until `rsp_ready`=1, then go to READY. The TAP idles in RTI with `tms`=0 meanwhile.
- TAP_RESET: `tms`=1 for 5 edges (reaches TLR from any state), then `tms`=0 for 1 edge (RTI). No response.
- IDLE_CYC: `cmd_len` edges in RTI with `tms`=0. No response. Length 0 returns to READY in one cycle.

Arithmetic and length rules:
- Bit counter is LEN_W wide; counts 0..N-1.
- `rsp_data` bits ≥N are 0.
- `cmd_len` > MAX_LEN is clamped to MAX_LEN.
- Scan with `cmd_len`=0: no TAP movement. `rsp_valid` rises the cycle after acceptance with `rsp_data`=0.

## Timing

Scan latency (edges from the acceptance edge to `rsp_valid`=1):
- DR scan of N bits: N+5.
- IR scan of N bits: N+6.
- Back-to-back scan: earliest next acceptance is the cycle after `rsp_valid`&&`rsp_ready`.

Other ops (acceptance edge to `cmd_ready` high again):
- TAP_RESET: 6 edges.
- IDLE_CYC of L: L edges, plus 1 if L>0.

Other timing rules:
- `tdo` is sampled at posedge while `tap_state`=Shift-xR; the target is assumed to update it on negedge.
- `trst` mid-operation: all state cleared on that edge, `rsp_valid` drops, the partial capture is lost, and the WALK_RTI sequence restarts.
- Payload signals (`cmd_*`) are sampled only at acceptance and latched internally.

## Structure

- `jtag_pkg`:
  - `tap_state_e` (16 states, IEEE encoding).
  - `jtag_op_e`.
  - function `tap_next(tap_state_e, logic tms)`.
  - Constants for the NAV tms sequences.
- Sub-module `jtag_tap_mirror`: registered `tap_state` plus `tap_next`, with reset to TLR.
- Controller FSM, counter, and data/capture shift registers live in `jtag_scan_ctrl`.

## Test plan

- Reset release:
  - Stimulus: `trst` high for 3 cycles, then low.
  - Response: `tms`=1, `rsp_valid`=0 during reset; one `tms`=0 edge; `tap_state`=RTI (0xC); `cmd_ready`=1 the following cycle.
- DR scan:
  - Stimulus: `cmd_len`=8, `cmd_data`=0xA5; TAP model DR returns 0x3C.
  - Response: tms 1,0,0,0×7,1,1,0; `tdi` bits 1,0,1,0,0,1,0,1; `rsp_data`=0x0000003C, `rsp_valid` 13 edges after acceptance.
- IR scan:
  - Stimulus: `cmd_len`=4, data 0xE; model IR captures 0x1.
  - Response: tms 1,1,0,0,0,0,0,1,1,0; `rsp_data`=0x1 after 10 edges.
- Response backpressure:
  - Stimulus: `rsp_ready`=0 for 20 cycles after a DR scan; then a second command is offered.
  - Response: `rsp_data` stable; `tms`=0, `tap_state`=RTI; `cmd_ready`=0 until the handshake; second command accepted the cycle after it.
- Reset mid-scan:
  - Stimulus: `trst` asserted at bit 5 of a 32-bit DR scan.
  - Response: no `rsp_valid`; `tap_state`=TLR, then RTI; the next scan returns correct data.
- Non-scan ops:
  - Stimulus: TAP_RESET, IDLE_CYC length 3, then SCAN_DR length 0.
  - Responses:
    - TAP_RESET: 5 `tms`=1 edges then RTI; `cmd_ready` after 6 edges.
    - IDLE_CYC: 3 edges with `tms`=0.
    - SCAN_DR length 0: `rsp_data`=0 one cycle after acceptance, no `tms` change.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared types and helpers for the JTAG scan sequencer: IEEE 1149.1 TAP
// state encoding, command opcodes, controller states and the TAP transition function.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EX2_DR = 4'h0,
    TAP_EX1_DR = 4'h1,
    TAP_SH_DR  = 4'h2,
    TAP_PAU_DR = 4'h3,
    TAP_SEL_IR = 4'h4,
    TAP_UPD_DR = 4'h5,
    TAP_CAP_DR = 4'h6,
    TAP_SEL_DR = 4'h7,
    TAP_EX2_IR = 4'h8,
    TAP_EX1_IR = 4'h9,
    TAP_SH_IR  = 4'hA,
    TAP_PAU_IR = 4'hB,
    TAP_RTI    = 4'hC,
    TAP_UPD_IR = 4'hD,
    TAP_CAP_IR = 4'hE,
    TAP_TLR    = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    OP_TAP_RESET = 2'd0,
    OP_SCAN_IR   = 2'd1,
    OP_SCAN_DR   = 2'd2,
    OP_IDLE_CYC  = 2'd3
  } jtag_op_e;

  typedef enum logic [2:0] {
    CTRL_WALK_RTI = 3'd0,
    CTRL_READY    = 3'd1,
    CTRL_NAV      = 3'd2,
    CTRL_SHIFT    = 3'd3,
    CTRL_EXIT     = 3'd4,
    CTRL_RUNIDLE  = 3'd5,
    CTRL_TLR_SEQ  = 3'd6,
    CTRL_RESP     = 3'd7
  } ctrl_state_e;

  // NAV tms sequences from RTI to Shift-xR, bit k is the k-th value driven.
  localparam logic [3:0] NAV_DR_TMS  = 4'b0001;
  localparam logic [1:0] NAV_DR_LAST = 2'd2;
  localparam logic [3:0] NAV_IR_TMS  = 4'b0011;
  localparam logic [1:0] NAV_IR_LAST = 2'd3;

  localparam int unsigned TLR_TMS_ONES = 5;

  function automatic tap_state_e tap_next(input tap_state_e cur, input logic tms);
    tap_state_e nxt;
    case (cur)
      TAP_TLR:    nxt = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    nxt = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: nxt = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: nxt = tms ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: nxt = tms ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: nxt = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: nxt = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: nxt = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: nxt = tms ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: nxt = tms ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: nxt = tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: nxt = tms ? TAP_SEL_DR : TAP_RTI;
      default:    nxt = TAP_TLR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_mirror.sv
// Local copy of the target TAP state, advanced on every clock edge from
// the tms value the sequencer is currently driving.
module jtag_tap_mirror
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tms,
  output tap_state_e state
);

  tap_state_e state_q;
  tap_state_e state_d;

  // Next TAP state from the IEEE graph.
  always_comb begin
    state_d = tap_next(state_q, tms);
  end

  // TAP state register, reset to Test-Logic-Reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TAP_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_scan_ctrl.sv
// Master-side JTAG scan sequencer: takes scan/reset/idle commands, drives
// tms/tdi through the TAP graph and returns captured tdo words.
module jtag_scan_ctrl
  import jtag_pkg::*;
#(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic [3:0]         tap_state
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  ctrl_state_e        state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [IDX_W-1:0]   cap_idx_q, cap_idx_d;
  logic               is_ir_q, is_ir_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;

  tap_state_e         tap_q;
  logic [LEN_W-1:0]   len_eff;
  logic [3:0]         nav_seq;
  logic [1:0]         nav_last;

  jtag_tap_mirror u_tap_mirror (
    .clk   (tck),
    .rst   (trst),
    .tms   (tms_q),
    .state (tap_q)
  );

  assign len_eff = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;

  // Controller next-state, tms/tdi sequencing and tdo capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    data_d      = data_q;
    is_ir_d     = is_ir_q;
    cap_d       = cap_q;
    cap_idx_d   = cap_idx_q;
    rsp_valid_d = rsp_valid_q;
    tms_d       = 1'b0;
    tdi_d       = 1'b0;
    nav_seq     = is_ir_q ? NAV_IR_TMS : NAV_DR_TMS;
    nav_last    = is_ir_q ? NAV_IR_LAST : NAV_DR_LAST;

    // tdo is stable from the target's negedge update while the mirror sits in Shift-xR.
    if ((tap_q == TAP_SH_DR) || (tap_q == TAP_SH_IR)) begin
      cap_d[cap_idx_q] = tdo;
      cap_idx_d        = cap_idx_q + IDX_W'(1);
    end else begin
      cap_idx_d = cap_idx_q;
    end

    case (state_q)
      CTRL_WALK_RTI: begin
        if (cnt_q == LEN_W'(0)) begin
          cnt_d = LEN_W'(1);
        end else begin
          cnt_d   = LEN_W'(0);
          state_d = CTRL_READY;
        end
      end
      CTRL_READY: begin
        if (cmd_valid) begin
          case (jtag_op_e'(cmd_op))
            OP_TAP_RESET: begin
              tms_d   = 1'b1;
              cnt_d   = LEN_W'(1);
              state_d = CTRL_TLR_SEQ;
            end
            OP_IDLE_CYC: begin
              len_d = len_eff;
              cnt_d = LEN_W'(0);
              if (len_eff == LEN_W'(0)) begin
                state_d = CTRL_READY;
              end else begin
                state_d = CTRL_RUNIDLE;
              end
            end
            OP_SCAN_IR, OP_SCAN_DR: begin
              len_d     = len_eff;
              data_d    = cmd_data;
              is_ir_d   = (jtag_op_e'(cmd_op) == OP_SCAN_IR);
              cap_d     = '0;
              cap_idx_d = IDX_W'(0);
              if (len_eff == LEN_W'(0)) begin
                rsp_valid_d = 1'b1;
                state_d     = CTRL_RESP;
              end else begin
                tms_d   = 1'b1;
                cnt_d   = LEN_W'(1);
                state_d = CTRL_NAV;
              end
            end
            default: state_d = CTRL_READY;
          endcase
        end else begin
          state_d = CTRL_READY;
        end
      end
      CTRL_NAV: begin
        tms_d = nav_seq[cnt_q[1:0]];
        if (cnt_q[1:0] == nav_last) begin
          cnt_d   = LEN_W'(0);
          state_d = CTRL_SHIFT;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      CTRL_SHIFT: begin
        tdi_d  = data_q[0];
        data_d = data_q >> 1;
        if (cnt_q == (len_q - LEN_W'(1))) begin
          tms_d   = 1'b1;
          cnt_d   = LEN_W'(0);
          state_d = CTRL_EXIT;
        end else begin
          tms_d = 1'b0;
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      CTRL_EXIT: begin
        // Exit1 -> Update -> RTI, response raised on the edge that lands in RTI.
        if (cnt_q == LEN_W'(0)) begin
          tms_d = 1'b1;
          cnt_d = LEN_W'(1);
        end else if (cnt_q == LEN_W'(1)) begin
          tms_d = 1'b0;
          cnt_d = LEN_W'(2);
        end else begin
          tms_d       = 1'b0;
          cnt_d       = LEN_W'(0);
          rsp_valid_d = 1'b1;
          state_d     = CTRL_RESP;
        end
      end
      CTRL_RUNIDLE: begin
        if (cnt_q == len_q) begin
          cnt_d   = LEN_W'(0);
          state_d = CTRL_READY;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      CTRL_TLR_SEQ: begin
        tms_d = (cnt_q < LEN_W'(TLR_TMS_ONES));
        if (cnt_q == LEN_W'(TLR_TMS_ONES + 1)) begin
          cnt_d   = LEN_W'(0);
          state_d = CTRL_READY;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      CTRL_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = CTRL_READY;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        cnt_d   = LEN_W'(0);
        state_d = CTRL_WALK_RTI;
      end
    endcase

    cmd_ready_d = (state_d == CTRL_READY);
  end

  // Controller registers; trst discards any command in flight.
  always_ff @(posedge tck) begin
    if (trst) begin
      state_q     <= CTRL_WALK_RTI;
      cnt_q       <= LEN_W'(0);
      len_q       <= LEN_W'(0);
      data_q      <= '0;
      cap_q       <= '0;
      cap_idx_q   <= IDX_W'(0);
      is_ir_q     <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      cap_idx_q   <= cap_idx_d;
      is_ir_q     <= is_ir_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = cap_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign tap_state = tap_q;

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Directed bench for jtag_scan_ctrl with a behavioural target TAP that
// captures fixed IR/DR words and records the tdi bits it shifts in.
module tb_jtag_scan_ctrl;

  localparam int          MAX_LEN = 32;
  localparam int          LEN_W   = 6;
  localparam logic [31:0] DR_CAP  = 32'h0000_003C;
  localparam logic [31:0] IR_CAP  = 32'h0000_0001;

  logic              tck       = 1'b0;
  logic              trst      = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op    = 2'd0;
  logic [LEN_W-1:0]  cmd_len   = 6'd0;
  logic [31:0]       cmd_data  = 32'd0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_data;
  logic              tms;
  logic              tdi;
  logic              tdo       = 1'b0;
  logic [3:0]        tap_state;

  int errors = 0;
  int checks = 0;
  int lat;

  logic [3:0]  m_st     = 4'hF;
  logic [31:0] dr_sr    = 32'd0;
  logic [31:0] ir_sr    = 32'd0;
  logic [31:0] shin     = 32'd0;
  int          sh_cnt   = 0;
  logic [31:0] tms_hist = 32'd0;

  always #5 tck = ~tck;

  jtag_scan_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .tck       (tck),
    .trst      (trst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .tap_state (tap_state)
  );

  function automatic logic [3:0] ref_next(input logic [3:0] s, input logic t);
    case (s)
      4'hF: return t ? 4'hF : 4'hC;
      4'hC: return t ? 4'h7 : 4'hC;
      4'h7: return t ? 4'h4 : 4'h6;
      4'h6: return t ? 4'h1 : 4'h2;
      4'h2: return t ? 4'h1 : 4'h2;
      4'h1: return t ? 4'h5 : 4'h3;
      4'h3: return t ? 4'h0 : 4'h3;
      4'h0: return t ? 4'h5 : 4'h2;
      4'h5: return t ? 4'h7 : 4'hC;
      4'h4: return t ? 4'hF : 4'hE;
      4'hE: return t ? 4'h9 : 4'hA;
      4'hA: return t ? 4'h9 : 4'hA;
      4'h9: return t ? 4'hD : 4'hB;
      4'hB: return t ? 4'h8 : 4'hB;
      4'h8: return t ? 4'hD : 4'hA;
      4'hD: return t ? 4'h7 : 4'hC;
      default: return 4'hF;
    endcase
  endfunction

  // Target TAP: capture, shift and state advance on posedge.
  always @(posedge tck) begin
    if (trst) begin
      m_st <= 4'hF;
    end else begin
      case (m_st)
        4'h6: begin dr_sr <= DR_CAP; shin <= 32'd0; sh_cnt <= 0; end
        4'hE: begin ir_sr <= IR_CAP; shin <= 32'd0; sh_cnt <= 0; end
        4'h2: begin
          dr_sr  <= {tdi, dr_sr[31:1]};
          shin   <= shin | (32'(tdi) << sh_cnt);
          sh_cnt <= sh_cnt + 1;
        end
        4'hA: begin
          ir_sr  <= {tdi, ir_sr[31:1]};
          shin   <= shin | (32'(tdi) << sh_cnt);
          sh_cnt <= sh_cnt + 1;
        end
        default: ;
      endcase
      m_st <= ref_next(m_st, tms);
    end
  end

  // Target drives tdo on the falling edge.
  always @(negedge tck) begin
    tdo <= (m_st == 4'h2) ? dr_sr[0] : ((m_st == 4'hA) ? ir_sr[0] : 1'b0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    tms_hist = {tms_hist[30:0], tms};
    @(posedge tck);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_len   = 6'd0;
    cmd_data  = 32'd0;
    tms_hist  = 32'd0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (cmd_ready !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    // Reset held for three edges.
    #1;
    repeat (3) tick();
    chk("rst_tms", 32'(tms), 32'd1);
    chk("rst_tdi", 32'(tdi), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_tap", 32'(tap_state), 32'hF);
    chk("rst_rsp_data", rsp_data, 32'd0);

    trst = 1'b0;
    tick();
    chk("walk_tms", 32'(tms), 32'd0);
    chk("walk_tap_tlr", 32'(tap_state), 32'hF);
    chk("walk_not_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("walk_tap_rti", 32'(tap_state), 32'hC);
    chk("walk_ready", 32'(cmd_ready), 32'd1);

    // DR scan, 8 bits of 0xA5.
    send(2'd2, 6'd8, 32'h0000_00A5);
    chk("dr_ready_low", 32'(cmd_ready), 32'd0);
    wait_rsp(lat);
    chk("dr_latency", 32'(lat), 32'd13);
    chk("dr_tms_seq", tms_hist, 32'h0000_1006);
    chk("dr_tdi_bits", shin, 32'h0000_00A5);
    chk("dr_rsp_data", rsp_data, 32'h0000_003C);
    chk("dr_tap_rti", 32'(tap_state), 32'hC);
    chk("dr_tap_model", 32'(tap_state), 32'(m_st));
    take_rsp();
    chk("dr_ready_after", 32'(cmd_ready), 32'd1);

    // IR scan, 4 bits of 0xE.
    send(2'd1, 6'd4, 32'h0000_000E);
    wait_rsp(lat);
    chk("ir_latency", 32'(lat), 32'd10);
    chk("ir_tms_seq", tms_hist, 32'h0000_0306);
    chk("ir_tdi_bits", shin, 32'h0000_000E);
    chk("ir_rsp_data", rsp_data, 32'h0000_0001);
    chk("ir_tap_rti", 32'(tap_state), 32'hC);
    take_rsp();

    // Backpressure, with a second command offered while the response waits.
    send(2'd2, 6'd8, 32'h0000_005A);
    wait_rsp(lat);
    chk("bp_latency", 32'(lat), 32'd13);
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_len   = 6'd4;
    cmd_data  = 32'h0000_0003;
    for (int i = 0; i < 20; i++) begin
      chk("bp_rsp_data", rsp_data, 32'h0000_003C);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_tms", 32'(tms), 32'd0);
      chk("bp_tap", 32'(tap_state), 32'hC);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_rsp_drop", 32'(rsp_valid), 32'd0);
    chk("bp_ready_next", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    tms_hist  = 32'd0;
    chk("bp_second_accepted", 32'(cmd_ready), 32'd0);
    wait_rsp(lat);
    chk("bp2_latency", 32'(lat), 32'd9);
    chk("bp2_rsp_data", rsp_data, 32'h0000_000C);
    chk("bp2_tdi_bits", shin, 32'h0000_0003);
    take_rsp();

    // Reset at bit 5 of a 32-bit DR scan.
    send(2'd2, 6'd32, 32'hDEAD_BEEF);
    repeat (8) tick();
    chk("mid_in_shift", 32'(tap_state), 32'h2);
    chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    trst = 1'b1;
    tick();
    chk("mid_rst_tap", 32'(tap_state), 32'hF);
    chk("mid_rst_tms", 32'(tms), 32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_data", rsp_data, 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    trst = 1'b0;
    tick();
    tick();
    chk("mid_tap_rti", 32'(tap_state), 32'hC);
    chk("mid_ready", 32'(cmd_ready), 32'd1);
    chk("mid_no_rsp_after", 32'(rsp_valid), 32'd0);
    send(2'd2, 6'd32, 32'h1234_5678);
    wait_rsp(lat);
    chk("post_latency", 32'(lat), 32'd37);
    chk("post_rsp_data", rsp_data, 32'h0000_003C);
    chk("post_tdi_bits", shin, 32'h1234_5678);
    take_rsp();

    // TAP_RESET.
    send(2'd0, 6'd0, 32'd0);
    wait_ready(lat);
    chk("tlr_latency", 32'(lat), 32'd6);
    chk("tlr_tms_seq", tms_hist, 32'h0000_003E);
    chk("tlr_tap_rti", 32'(tap_state), 32'hC);
    chk("tlr_tap_model", 32'(tap_state), 32'(m_st));
    chk("tlr_no_rsp", 32'(rsp_valid), 32'd0);

    // IDLE_CYC of 3, then of 0.
    send(2'd3, 6'd3, 32'd0);
    wait_ready(lat);
    chk("idle3_latency", 32'(lat), 32'd4);
    chk("idle3_tms_seq", tms_hist, 32'd0);
    chk("idle3_tap", 32'(tap_state), 32'hC);
    chk("idle3_no_rsp", 32'(rsp_valid), 32'd0);
    send(2'd3, 6'd0, 32'd0);
    chk("idle0_ready", 32'(cmd_ready), 32'd1);

    // Zero-length DR scan.
    send(2'd2, 6'd0, 32'hFFFF_FFFF);
    chk("len0_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("len0_rsp_data", rsp_data, 32'd0);
    chk("len0_tms", 32'(tms), 32'd0);
    chk("len0_tap", 32'(tap_state), 32'hC);
    take_rsp();

    // Over-length scan is clamped to 32 bits.
    send(2'd2, 6'd40, 32'hFFFF_FFFF);
    wait_rsp(lat);
    chk("clamp_latency", 32'(lat), 32'd37);
    chk("clamp_rsp_data", rsp_data, 32'h0000_003C);
    chk("clamp_tdi_bits", shin, 32'hFFFF_FFFF);
    take_rsp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
